// File: rtl/inv_mixcolumn_iter_128.sv
// Purpose     : AES InvMixColumns over a 128-bit state, COLS_PER_CYCLE columns per clock.
// Latency     : out_valid rises 4/COLS_PER_CYCLE edges after the accepting edge.
// Backpressure: one state in flight; in_ready only in IDLE, result held until out_ready.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake; in_data sampled on the accepting edge
//   in_data [127:0]       state, column c = bits [127-32c -: 32], row 0 byte = column MSB
//   out_valid/out_ready   output handshake; out_data stable while stalled
//   out_data [127:0]      InvMixColumns(in_data), same layout; holds last result in IDLE
//   busy                  high while columns are being transformed
//
// COLS_PER_CYCLE must be 1, 2 or 4 so that the column index lands exactly on 4.

module inv_mixcolumn_iter_128 #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Column step, one bit wider than the index so that the final step shows up as
  // a carry into bit 2 (idx + N == 4) regardless of N.
  localparam logic [2:0] COL_STEP = 3'(COLS_PER_CYCLE);

  logic [1:0]   state_q;
  logic [1:0]   idx_q;
  logic [127:0] data_q;

  logic [31:0]  col_cur [4];
  logic [31:0]  col_nxt [4];
  logic [127:0] data_nxt;
  logic [1:0]   sel;
  logic [2:0]   idx_sum;
  logic         last_step;

  // ---------------------------------------------------------------------------
  // GF(2^8) arithmetic, reduction polynomial 0x11B. Every constant multiply is
  // an XOR of the x1/x2/x4/x8 terms produced by an xtime chain.
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
  endfunction

  function automatic logic [7:0] mul09(input logic [7:0] b);
    logic [7:0] x8;
    x8 = xtime(xtime(xtime(b)));
    return x8 ^ b;
  endfunction

  function automatic logic [7:0] mul0b(input logic [7:0] b);
    logic [7:0] x2;
    logic [7:0] x8;
    x2 = xtime(b);
    x8 = xtime(xtime(x2));
    return x8 ^ x2 ^ b;
  endfunction

  function automatic logic [7:0] mul0d(input logic [7:0] b);
    logic [7:0] x4;
    logic [7:0] x8;
    x4 = xtime(xtime(b));
    x8 = xtime(x4);
    return x8 ^ x4 ^ b;
  endfunction

  function automatic logic [7:0] mul0e(input logic [7:0] b);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

  // One column: bytes a (MSB) .. d (LSB) through the circulant {0e,0b,0d,09}.
  function automatic logic [31:0] inv_column(input logic [31:0] col);
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
    logic [7:0] d;
    logic [7:0] o0;
    logic [7:0] o1;
    logic [7:0] o2;
    logic [7:0] o3;
    a  = col[31:24];
    b  = col[23:16];
    c  = col[15:8];
    d  = col[7:0];
    o0 = mul0e(a) ^ mul0b(b) ^ mul0d(c) ^ mul09(d);
    o1 = mul09(a) ^ mul0e(b) ^ mul0b(c) ^ mul0d(d);
    o2 = mul0d(a) ^ mul09(b) ^ mul0e(c) ^ mul0b(d);
    o3 = mul0b(a) ^ mul0d(b) ^ mul09(c) ^ mul0e(d);
    return {o0, o1, o2, o3};
  endfunction

  // ---------------------------------------------------------------------------
  // Datapath: split the register into columns, rewrite the N columns starting
  // at idx_q, and repack. Columns outside the window pass through unchanged.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      col_cur[c] = data_q[127 - 32*c -: 32];
    end
  end

  always_comb begin
    sel = idx_q;
    for (int c = 0; c < 4; c++) begin
      col_nxt[c] = col_cur[c];
    end
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      sel          = idx_q + 2'(k);
      col_nxt[sel] = inv_column(col_cur[sel]);
    end
  end

  always_comb begin
    data_nxt = '0;
    for (int c = 0; c < 4; c++) begin
      data_nxt[127 - 32*c -: 32] = col_nxt[c];
    end
  end

  // idx_q only ever holds multiples of N, so the step that processes column 3
  // is exactly the one whose sum reaches 4; the 2-bit index then wraps to 0.
  assign idx_sum   = {1'b0, idx_q} + COL_STEP;
  assign last_step = idx_sum[2];

  // ---------------------------------------------------------------------------
  // Control
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            data_q  <= in_data;
            idx_q   <= 2'd0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          data_q <= data_nxt;
          idx_q  <= idx_sum[1:0];
          if (last_step) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          idx_q   <= 2'd0;
        end
      endcase
    end
  end

  // Outputs decode straight from registered state so reset reaches them at once.
  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == BUSY);
  assign out_valid = (state_q == DONE);
  assign out_data  = data_q;

endmodule
